// File: rtl/seq_window_monitor_if.sv
// Bundle of the control, stimulus and result signals of seq_window_monitor.
// Latency: none (wires only). Backpressure: none, the monitor samples every cycle.
// Ports: en/clr/trig/resp go from master to slave; pass/fail/fail_sticky/pending/counters go back.
interface seq_window_monitor_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic                 en;
  logic                 clr;
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       resp;
  logic [NCH-1:0]       pass;
  logic [NCH-1:0]       fail;
  logic [NCH-1:0]       fail_sticky;
  logic [NCH-1:0]       pending;
  logic [NCH*CNT_W-1:0] pass_cnt;
  logic [NCH*CNT_W-1:0] fail_cnt;

  // Stimulus side (bench or surrounding checker).
  modport master (
    output en, clr, trig, resp,
    input  pass, fail, fail_sticky, pending, pass_cnt, fail_cnt
  );

  // Monitor side.
  modport slave (
    input  en, clr, trig, resp,
    output pass, fail, fail_sticky, pending, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_window_monitor.sv
// Per-channel monitor for trig ##[MIN_DLY:MAX_DLY] resp (or ##[MIN_DLY:$] when UNBOUNDED=1).
// Latency: decisions made on the edge that samples resp are visible one cycle later.
// Backpressure: none; every cycle is sampled and overlapping attempts are tracked independently.
// Ports: clk, rst (async, active high); bus.slave carries en, clr, trig[NCH], resp[NCH] in and
//        pass, fail, fail_sticky, pending [NCH] plus pass_cnt/fail_cnt (channel i at [i*CNT_W +: CNT_W]) out.
module seq_window_monitor #(
  parameter int NCH       = 4,
  parameter int MIN_DLY   = 1,
  parameter int MAX_DLY   = 4,
  parameter int UNBOUNDED = 0,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  seq_window_monitor_if.slave bus
);

  // Deepest age tracked explicitly. In unbounded mode anything older than
  // MIN_DLY is folded into a single wait bit, so only ages up to MIN_DLY matter.
  localparam int D = (UNBOUNDED != 0) ? MIN_DLY : MAX_DLY;

  // Ages that a resp in the current cycle can satisfy. Bounded mode never holds
  // ages above MAX_DLY and unbounded mode never above MIN_DLY, so the lower
  // bound is the only one that needs encoding here.
  function automatic logic [D:0] win_mask();
    logic [D:0] m;
    m = '0;
    for (int k = 0; k <= D; k++) begin
      m[k] = (k >= MIN_DLY);
    end
    return m;
  endfunction

  localparam logic [D:0] WIN = win_mask();

  // Registered state. Bit k of age_q[ch] = an attempt started k cycles ago is
  // still open. Bit 0 is never set in the register; the new attempt of the
  // current cycle is merged into bit 0 combinationally.
  logic [D:0]                age_q [NCH];
  logic [NCH-1:0]            wait_q;
  logic [NCH-1:0]            pass_q;
  logic [NCH-1:0]            fail_q;
  logic [NCH-1:0]            sticky_q;
  logic [NCH-1:0]            pend_q;
  logic [NCH-1:0][CNT_W-1:0] pcnt_q;
  logic [NCH-1:0][CNT_W-1:0] fcnt_q;

  // Next-state / decision signals.
  logic [D:0]     age_d [NCH];
  logic [NCH-1:0] wait_d;
  logic [NCH-1:0] pass_d;
  logic [NCH-1:0] fail_d;
  logic [NCH-1:0] pend_d;

  always_comb begin
    logic [D:0] cur;
    cur    = '0;
    wait_d = '0;
    pass_d = '0;
    fail_d = '0;
    pend_d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      age_d[ch] = '0;
    end

    for (int ch = 0; ch < NCH; ch++) begin
      // Live attempts this cycle, including the one being started now.
      cur    = age_q[ch];
      cur[0] = cur[0] | (bus.trig[ch] & bus.en);

      if (bus.resp[ch]) begin
        // Everything inside the window completes; the wait bit (unbounded
        // mode) also completes. One pulse covers however many resolved.
        pass_d[ch] = (|(cur & WIN)) | wait_q[ch];
      end else if (UNBOUNDED != 0) begin
        // Oldest explicit age becomes an open-ended wait.
        wait_d[ch] = wait_q[ch] | cur[D];
      end else begin
        // Oldest age has run out of window: at most one failure per cycle.
        fail_d[ch] = cur[D];
      end

      // Shift survivors one age older. Age D never survives: it either
      // passed, failed, or moved into the wait bit above.
      for (int k = 1; k <= D; k++) begin
        age_d[ch][k] = cur[k-1] & ~(bus.resp[ch] & WIN[k-1]);
      end

      pend_d[ch] = (|age_d[ch]) | wait_d[ch];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        age_q[ch] <= '0;
      end
      wait_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      sticky_q <= '0;
      pend_q   <= '0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
    end else if (bus.clr) begin
      // clr wins over anything decided this cycle: those events are dropped.
      for (int ch = 0; ch < NCH; ch++) begin
        age_q[ch] <= '0;
      end
      wait_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      sticky_q <= '0;
      pend_q   <= '0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        age_q[ch] <= age_d[ch];
      end
      wait_q   <= wait_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      sticky_q <= sticky_q | fail_d;
      pend_q   <= pend_d;
      for (int ch = 0; ch < NCH; ch++) begin
        // Saturating counters: hold at all-ones instead of wrapping.
        if (pass_d[ch] && (pcnt_q[ch] != '1)) begin
          pcnt_q[ch] <= pcnt_q[ch] + CNT_W'(1);
        end
        if (fail_d[ch] && (fcnt_q[ch] != '1)) begin
          fcnt_q[ch] <= fcnt_q[ch] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.fail_sticky = sticky_q;
  assign bus.pending     = pend_q;
  assign bus.pass_cnt    = pcnt_q;
  assign bus.fail_cnt    = fcnt_q;

endmodule

// File: tb/tb_seq_window_monitor.sv
// Bench for seq_window_monitor: five differently configured instances share one stimulus
// stream; an attempt-list model (start times per channel) predicts every output each cycle.
// Directed sequences with literal expectations come first, then randomized traffic.
module tb_seq_window_monitor;
  localparam int NI  = 5;
  localparam int NCH = 4;

  // Instance configurations.
  function automatic int cfg_min(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 0;
      default: return 1;
    endcase
  endfunction
  function automatic int cfg_max(int i);
    case (i)
      0: return 1;
      1: return 5;
      2: return 0;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_unb(int i);
    return (i == 3) ? 1 : 0;
  endfunction
  function automatic int cfg_cw(int i);
    return (i == 4) ? 2 : 16;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [NCH-1:0] trig = '0;
  logic [NCH-1:0] resp = '0;

  always #5 clk = ~clk;

  logic [NCH-1:0] d_pass [NI];
  logic [NCH-1:0] d_fail [NI];
  logic [NCH-1:0] d_stk  [NI];
  logic [NCH-1:0] d_pend [NI];
  logic [63:0]    d_pcnt [NI][NCH];
  logic [63:0]    d_fcnt [NI][NCH];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = cfg_cw(gi);
    seq_window_monitor_if #(.NCH(NCH), .CNT_W(CW)) bus ();
    assign bus.en   = en;
    assign bus.clr  = clr;
    assign bus.trig = trig;
    assign bus.resp = resp;
    seq_window_monitor #(
      .NCH(NCH), .MIN_DLY(cfg_min(gi)), .MAX_DLY(cfg_max(gi)),
      .UNBOUNDED(cfg_unb(gi)), .CNT_W(CW)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign d_pass[gi] = bus.pass;
    assign d_fail[gi] = bus.fail;
    assign d_stk[gi]  = bus.fail_sticky;
    assign d_pend[gi] = bus.pending;
    for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
      assign d_pcnt[gi][gc] = 64'(bus.pass_cnt[gc*CW +: CW]);
      assign d_fcnt[gi][gc] = 64'(bus.fail_cnt[gc*CW +: CW]);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: every open attempt is remembered by its start cycle; its age is
  // the distance to the current cycle.
  int          starts [NI][NCH][$];
  int          cyc = 0;
  logic [NCH-1:0] e_pass [NI];
  logic [NCH-1:0] e_fail [NI];
  logic [NCH-1:0] e_stk  [NI];
  logic [NCH-1:0] e_pend [NI];
  logic [63:0]    e_pcnt [NI][NCH];
  logic [63:0]    e_fcnt [NI][NCH];

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      e_pass[i] = '0; e_fail[i] = '0; e_stk[i] = '0; e_pend[i] = '0;
      for (int c = 0; c < NCH; c++) begin
        starts[i][c].delete();
        e_pcnt[i][c] = 0;
        e_fcnt[i][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int mn, mx, unb;
      logic [63:0] cmax;
      mn   = cfg_min(i);
      mx   = cfg_max(i);
      unb  = cfg_unb(i);
      cmax = (64'd1 << cfg_cw(i)) - 64'd1;
      for (int c = 0; c < NCH; c++) begin
        if (clr) begin
          starts[i][c].delete();
          e_pass[i][c] = 0; e_fail[i][c] = 0; e_stk[i][c] = 0; e_pend[i][c] = 0;
          e_pcnt[i][c] = 0; e_fcnt[i][c] = 0;
        end else begin
          int keep [$];
          bit passed, failed;
          passed = 0;
          failed = 0;
          if (en && trig[c]) starts[i][c].push_back(cyc);
          for (int k = 0; k < starts[i][c].size(); k++) begin
            int age;
            bit inwin;
            age   = cyc - starts[i][c][k];
            inwin = (age >= mn) && (unb != 0 || age <= mx);
            if (resp[c] && inwin) passed = 1;
            else if (!resp[c] && unb == 0 && age == mx) failed = 1;
            else keep.push_back(starts[i][c][k]);
          end
          starts[i][c] = keep;
          e_pass[i][c] = passed;
          e_fail[i][c] = failed;
          e_stk[i][c]  = e_stk[i][c] | failed;
          e_pend[i][c] = (keep.size() != 0);
          if (passed && e_pcnt[i][c] < cmax) e_pcnt[i][c] = e_pcnt[i][c] + 1;
          if (failed && e_fcnt[i][c] < cmax) e_fcnt[i][c] = e_fcnt[i][c] + 1;
        end
      end
    end
    cyc++;
  endtask

  // Compare every output of every instance against the model, away from the edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("u%0d.pass[%0d]", i, c), 64'(d_pass[i][c]), 64'(e_pass[i][c]));
        chk($sformatf("u%0d.fail[%0d]", i, c), 64'(d_fail[i][c]), 64'(e_fail[i][c]));
        chk($sformatf("u%0d.sticky[%0d]", i, c), 64'(d_stk[i][c]), 64'(e_stk[i][c]));
        chk($sformatf("u%0d.pending[%0d]", i, c), 64'(d_pend[i][c]), 64'(e_pend[i][c]));
        chk($sformatf("u%0d.pass_cnt[%0d]", i, c), d_pcnt[i][c], e_pcnt[i][c]);
        chk($sformatf("u%0d.fail_cnt[%0d]", i, c), d_fcnt[i][c], e_fcnt[i][c]);
      end
    end
  end

  task automatic step(logic e, logic c, logic [NCH-1:0] t, logic [NCH-1:0] r);
    en   = e;
    clr  = c;
    trig = t;
    resp = r;
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_rst();
    en = 1'b0; clr = 1'b0; trig = '0; resp = '0;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_pending_u4", 64'(d_pend[4]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pending_u1", 64'(d_pend[1]), 64'd0);
    chk("reset_pass_cnt_u0", d_pcnt[0][0], 64'd0);
    rst = 1'b0;

    // 1: MIN=MAX=1 on u0 ch0.
    step(1, 0, 4'b0001, 4'b0000);
    step(1, 0, 4'b0000, 4'b0001);
    chk("t1_pass", 64'(d_pass[0][0]), 64'd1);
    chk("t1_pass_cnt", d_pcnt[0][0], 64'd1);
    chk("t1_fail_cnt", d_fcnt[0][0], 64'd0);
    step(1, 0, 4'b0000, 4'b0000);
    chk("t1_pulse_end", 64'(d_pass[0][0]), 64'd0);

    // 2: MIN=2 MAX=5 on u1 ch1, no response -> fail after age 5.
    step(1, 0, 4'b0010, 4'b0000);
    repeat (4) step(1, 0, 4'b0000, 4'b0000);
    chk("t2_pending_before", 64'(d_pend[1][1]), 64'd1);
    chk("t2_no_early_fail", 64'(d_fail[1][1]), 64'd0);
    step(1, 0, 4'b0000, 4'b0000);
    chk("t2_fail", 64'(d_fail[1][1]), 64'd1);
    chk("t2_sticky", 64'(d_stk[1][1]), 64'd1);
    chk("t2_pending_after", 64'(d_pend[1][1]), 64'd0);

    // 3: two overlapping attempts resolved by a single resp on u1 ch0.
    step(1, 1, 4'b0000, 4'b0000);
    step(1, 0, 4'b0001, 4'b0000);
    step(1, 0, 4'b0001, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000);
    step(1, 0, 4'b0000, 4'b0001);
    chk("t3_pass", 64'(d_pass[1][0]), 64'd1);
    chk("t3_pass_cnt", d_pcnt[1][0], 64'd1);
    chk("t3_pending", 64'(d_pend[1][0]), 64'd0);

    // 4: ##0 on u2 ch2.
    step(1, 0, 4'b0100, 4'b0100);
    chk("t4_pass", 64'(d_pass[2][2]), 64'd1);
    step(1, 0, 4'b0000, 4'b0000);
    step(1, 0, 4'b0100, 4'b0000);
    chk("t4_fail", 64'(d_fail[2][2]), 64'd1);
    chk("t4_no_pass", 64'(d_pass[2][2]), 64'd0);

    // 5: unbounded on u3 ch3, resp 40 cycles later.
    step(1, 1, 4'b0000, 4'b0000);
    step(1, 0, 4'b1000, 4'b0000);
    chk("t5_pending_1", 64'(d_pend[3][3]), 64'd1);
    for (int k = 2; k <= 40; k++) begin
      step(1, 0, 4'b0000, 4'b0000);
      chk($sformatf("t5_pending_%0d", k), 64'(d_pend[3][3]), 64'd1);
      chk($sformatf("t5_no_fail_%0d", k), 64'(d_fail[3][3]), 64'd0);
    end
    step(1, 0, 4'b0000, 4'b1000);
    chk("t5_pass", 64'(d_pass[3][3]), 64'd1);
    chk("t5_pending_end", 64'(d_pend[3][3]), 64'd0);

    // 6: 2-bit counters on u4 ch0 saturate, clr beats resp, rst drops attempts.
    step(1, 1, 4'b0000, 4'b0000);
    repeat (5) step(1, 0, 4'b0001, 4'b0000);
    repeat (4) step(1, 0, 4'b0000, 4'b0000);
    chk("t6_fail_cnt_sat", d_fcnt[4][0], 64'd3);
    chk("t6_sticky", 64'(d_stk[4][0]), 64'd1);
    step(1, 0, 4'b0001, 4'b0000);
    step(1, 1, 4'b0000, 4'b0001);
    chk("t6_clr_no_pass", 64'(d_pass[4][0]), 64'd0);
    chk("t6_clr_pass_cnt", d_pcnt[4][0], 64'd0);
    chk("t6_clr_fail_cnt", d_fcnt[4][0], 64'd0);
    chk("t6_clr_sticky", 64'(d_stk[4][0]), 64'd0);
    step(1, 0, 4'b0001, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000);
    do_rst();
    repeat (6) step(1, 0, 4'b0000, 4'b0000);
    chk("t6_rst_no_fail_cnt", d_fcnt[4][0], 64'd0);
    chk("t6_rst_no_sticky", 64'(d_stk[4][0]), 64'd0);

    // Randomized traffic, alternating sparse-resp and dense-resp phases.
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] t, r;
      logic e, c;
      e = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 299) == 0);
      t = 4'($urandom) & 4'($urandom);
      if (((n / 500) % 2) == 0) r = 4'($urandom) & 4'($urandom) & 4'($urandom);
      else r = 4'($urandom);
      if ($urandom_range(0, 999) == 0) do_rst();
      step(e, c, t, r);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_window_monitor.md
Name: seq_window_monitor

Overview:
- Synthesizable multi-channel monitor for the sequence trig ##[MIN_DLY:MAX_DLY] resp, or trig ##[MIN_DLY:$] resp in unbounded mode.
- Used as the RTL reference model against which SVA delay-operator support is cross-checked in formal and sim flows.
- Tracks every overlapping attempt per channel independently.
- Reports per-attempt pass/fail pulses, sticky failure flags and saturating event counters.

Parameters:
NCH, 4, number of independent channels
MIN_DLY, 1, lower delay bound in cycles (0 allowed, gives ##0 semantics)
MAX_DLY, 4, upper delay bound; MIN_DLY <= MAX_DLY <= 63; ignored when UNBOUNDED=1
UNBOUNDED, 0, 1 selects ##[MIN_DLY:$]
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock, all sampling on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  new-attempt enable; in-flight attempts continue when low
clr  in  1  synchronous clear of attempts, sticky flags and counters
trig  in  NCH  per-channel attempt start
resp  in  NCH  per-channel response
pass  out  NCH  registered pulse: at least one attempt completed
fail  out  NCH  registered pulse: one attempt expired
fail_sticky  out  NCH  set by fail, cleared only by clr/rst
pending  out  NCH  registered: at least one unresolved attempt
pass_cnt  out  NCH*CNT_W  per-channel pass-cycle count, channel i at [i*CNT_W +: CNT_W]
fail_cnt  out  NCH*CNT_W  per-channel fail count, same packing

Behaviour:
- Reset: all outputs, attempt state and counters are 0 while rst is high and after release.
- Per channel, age vector age[1..MAX_DLY]. Bit k means an attempt started k cycles ago and is unresolved. A new attempt has age 0 in the cycle it is sampled: trig & en.
- Window set at cycle t: all live ages k with MIN_DLY <= k <= MAX_DLY, plus age 0 when MIN_DLY = 0.
- If resp = 1 at t: every attempt in the window set resolves as pass. Attempts with age < MIN_DLY are unaffected.
- If resp = 0 at t: the attempt at age MAX_DLY (or age 0 when MAX_DLY = 0) fails. At most one failure per channel per cycle.
- Surviving attempts shift to age k+1 at the next edge.
- Outputs are registered: pass/fail for decisions at cycle t are visible at t+1, for exactly one cycle. pending reflects state after the t edge.
- Pass and fail in the same cycle are impossible, because one resp value governs both.
- Unbounded mode:
  - Ages 1..MIN_DLY are tracked explicitly.
  - An attempt reaching age MIN_DLY with resp=0 merges into a single per-channel wait bit.
  - resp=1 clears the wait bit and counts as a pass.
  - fail never asserts; end-of-test checking uses pending.
- Counters: pass_cnt increments by 1 per cycle with pass; fail_cnt by 1 per fail. Both saturate at 2^CNT_W-1 with no wrap.
- clr: at the next edge, clears the age vector, wait bit, fail_sticky and counters. clr dominates; events decided in a clr cycle are dropped and pass/fail stay 0.
- Asserting rst mid-operation discards all in-flight attempts with no fail reported.
- en=0 blocks new attempts only; in-flight attempts age and resolve normally.
- Channels are fully independent; no cross-channel state.

Test Plan:
1. MIN=1, MAX=1, ch0: trig at cycle 10, resp at 11 -> pass[0] at 12, pass_cnt0=1, fail_cnt0=0.
2. MIN=2, MAX=5, ch1: trig at 0, resp low through cycle 5 -> fail[1] at 6, fail_sticky[1]=1, pending[1]=0 at 6.
3. MIN=2, MAX=5, ch0: trig at 0 and 1, resp only at 3 -> one pass pulse at 4 (both resolved), pass_cnt0=1, pending[0]=0 at 4.
4. MIN=0, MAX=0, ch2: trig&resp at 7 -> pass[2] at 8; trig&!resp at 9 -> fail[2] at 10.
5. UNBOUNDED=1, MIN=1, ch3: trig at 0, resp at 40 -> pending[3]=1 for cycles 1..40, pass at 41, fail never asserts.
6. CNT_W=2: force 5 fails -> fail_cnt saturates at 3. Assert clr during a resp cycle -> counters 0, no pass pulse. rst mid-attempt -> pending=0, no fail.
